// File: rtl/clk_ctrl_pkg.sv
// Shared encodings and defaults for the CPU clock controller.
package clk_ctrl_pkg;

  // State encoding doubles as the LED display code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } clk_state_e;

  localparam int unsigned PRESC_W             = 27;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_RATE0_EXP       = 18;
  localparam int unsigned DEF_RATE1_EXP       = 20;
  localparam int unsigned DEF_RATE2_EXP       = 24;
  localparam int unsigned DEF_RATE3_EXP       = 26;

  // Mask of the low exp_bits prescaler bits; an exponent of 0 yields an
  // empty mask, so the tick fires every cycle.
  function automatic logic [PRESC_W-1:0] rate_mask(input int unsigned exp_bits);
    rate_mask = PRESC_W'((64'd1 << exp_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce, rising-edge pulse.
module btn_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic mclk,
  input  logic clr,
  input  logic btn_raw,
  output logic btn_edge
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_ff1;
  logic             sync_ff2;
  logic             level_q;
  logic             level_prev;
  logic [CNT_W-1:0] cnt_q;

  // Bring the raw button into the mclk domain.
  always_ff @(posedge mclk) begin
    if (clr) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= btn_raw;
      sync_ff2 <= sync_ff1;
    end
  end

  // Accept a new level only after it has differed for the full window;
  // any return to the current level restarts the window.
  always_ff @(posedge mclk) begin
    if (clr) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync_ff2 == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= sync_ff2;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge mclk) begin
    if (clr) level_prev <= 1'b0;
    else     level_prev <= level_q;
  end

  assign btn_edge = level_q & ~level_prev;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable generator for the MIPS core: free-run at a selectable rate,
// single-step from a push-button, and halt on request from the core.
module cpu_clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RATE0_EXP       = DEF_RATE0_EXP,
  parameter int unsigned RATE1_EXP       = DEF_RATE1_EXP,
  parameter int unsigned RATE2_EXP       = DEF_RATE2_EXP,
  parameter int unsigned RATE3_EXP       = DEF_RATE3_EXP
) (
  input  logic        mclk,
  input  logic        clr,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic [1:0]  rate_sel,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);

  localparam logic [PRESC_W-1:0] RATE0_MASK = rate_mask(RATE0_EXP);
  localparam logic [PRESC_W-1:0] RATE1_MASK = rate_mask(RATE1_EXP);
  localparam logic [PRESC_W-1:0] RATE2_MASK = rate_mask(RATE2_EXP);
  localparam logic [PRESC_W-1:0] RATE3_MASK = rate_mask(RATE3_EXP);

  logic               run_ff1;
  logic               run_sync;
  logic               step_edge;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] tick_mask;
  logic               tick;
  clk_state_e         state_q;

  // Run switch synchronizer.
  always_ff @(posedge mclk) begin
    if (clr) begin
      run_ff1  <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_ff1  <= run_sw;
      run_sync <= run_ff1;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .mclk    (mclk),
    .clr     (clr),
    .btn_raw (step_btn),
    .btn_edge(step_edge)
  );

  // Free-running prescaler; wraps naturally at all-ones.
  always_ff @(posedge mclk) begin
    if (clr) presc_q <= '0;
    else     presc_q <= presc_q + 1'b1;
  end

  // Rate select only changes which bits are compared, so a new rate takes
  // effect at its next matching count without a stray pulse.
  always_comb begin
    tick_mask = RATE0_MASK;
    case (rate_sel)
      2'd0:    tick_mask = RATE0_MASK;
      2'd1:    tick_mask = RATE1_MASK;
      2'd2:    tick_mask = RATE2_MASK;
      default: tick_mask = RATE3_MASK;
    endcase
  end

  assign tick = ((presc_q & tick_mask) == tick_mask);

  // Run/step/halt sequencing; halt has priority over leaving RUN.
  always_ff @(posedge mclk) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_sync)       state_q <= ST_RUN;
          else if (step_edge) state_q <= ST_STEP;
        end
        ST_RUN: begin
          if (halt_req)       state_q <= ST_HALT;
          else if (!run_sync) state_q <= ST_IDLE;
        end
        ST_STEP:              state_q <= halt_req ? ST_HALT : ST_IDLE;
        ST_HALT: begin
          if (!run_sync)      state_q <= ST_IDLE;
        end
        default:              state_q <= ST_IDLE;
      endcase
    end
  end

  // Enable decode; halt_req suppresses a coincident tick, and clr kills any
  // enable in the reset cycle itself.
  always_comb begin
    cpu_ce = 1'b0;
    case (state_q)
      ST_RUN:  cpu_ce = tick & ~halt_req;
      ST_STEP: cpu_ce = 1'b1;
      default: cpu_ce = 1'b0;
    endcase
    if (clr) cpu_ce = 1'b0;
  end

  // Count issued enables.
  always_ff @(posedge mclk) begin
    if (clr)         cycle_cnt <= 32'd0;
    else if (cpu_ce) cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with short debounce and rate settings.
module tb_cpu_clk_ctrl;

  logic        mclk     = 1'b0;
  logic        clr      = 1'b1;
  logic        run_sw   = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RATE0_EXP(2),
    .RATE1_EXP(3),
    .RATE2_EXP(4),
    .RATE3_EXP(5)
  ) dut (
    .mclk     (mclk),
    .clr      (clr),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .rate_sel (rate_sel),
    .cpu_ce   (cpu_ce),
    .state    (state),
    .cycle_cnt(cycle_cnt)
  );

  always #5 mclk = ~mclk;

  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          last_pulse_cyc = -1;
  int          rate_exp [4] = '{2, 3, 4, 5};
  logic [26:0] pcyc = '0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_cnt = 32'd0;
  logic [31:0] exp_v;
  logic        prev_ce = 1'b0;

  // Cycle index and an independent model of the prescaler count.
  always @(posedge mclk) begin
    cyc_n <= cyc_n + 1;
    pcyc  <= clr ? 27'd0 : pcyc + 27'd1;
  end

  // Scoreboard: every observed enable must match a queued expectation.
  always @(negedge mclk) begin
    if (cpu_ce === 1'b1) begin
      last_pulse_cyc = cyc_n;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d state=%b cycle_cnt=%h expected no pulse", cyc_n, state, cycle_cnt);
      end else begin
        exp_v = exp_q.pop_front();
        if (cycle_cnt !== exp_v) begin
          failures++;
          $display("FAIL pulse_count cyc=%0d got=%h exp=%h", cyc_n, cycle_cnt, exp_v);
        end
      end
      if (prev_ce) begin
        checks++;
        failures++;
        $display("FAIL back_to_back_ce cyc=%0d got=two consecutive exp=single", cyc_n);
      end
    end
    prev_ce = (cpu_ce === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0; rate_sel = 2'd0;
    repeat (2) cyc();
    clr = 1'b0;
    exp_cnt = 32'd0;
    exp_q.delete();
    last_pulse_cyc = -1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) cyc();
    clr = 1'b0;
    exp_cnt = 32'd0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (state !== 2'b00) begin failures++; $display("FAIL reset_state i=%0d got=%b exp=00", i, state); end
      checks++;
      if (cpu_ce !== 1'b0) begin failures++; $display("FAIL reset_ce i=%0d got=%b exp=0", i, cpu_ce); end
      checks++;
      if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt i=%0d got=%h exp=0", i, cycle_cnt); end
    end
  endtask

  task automatic test_run(input int r, input int on_cycles);
    logic [26:0] m;
    m = 27'((1 << rate_exp[r]) - 1);
    rate_sel = r[1:0];
    run_sw = 1'b1;
    for (int i = 1; i <= on_cycles + 6; i++) begin
      cyc();
      if (i == on_cycles) run_sw = 1'b0;
      if (i == 3) begin
        checks++;
        if (state !== 2'b01) begin failures++; $display("FAIL run_entry rate=%0d got=%b exp=01", r, state); end
      end
      if (i >= 3 && i <= on_cycles + 2 && (pcyc & m) == m) begin
        exp_q.push_back(exp_cnt);
        exp_cnt = exp_cnt + 32'd1;
      end
    end
    checks++;
    if (state !== 2'b00) begin failures++; $display("FAIL run_exit rate=%0d got=%b exp=00", r, state); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL run_missed rate=%0d got=%0d pending exp=0", r, exp_q.size()); end
    checks++;
    if (cycle_cnt !== exp_cnt) begin failures++; $display("FAIL run_total rate=%0d got=%h exp=%h", r, cycle_cnt, exp_cnt); end
  endtask

  task automatic test_step_bounce();
    int s0;
    do_clr();
    s0 = cyc_n;
    step_btn = 1'b1; cyc();
    step_btn = 1'b0; cyc();
    step_btn = 1'b1;
    exp_q.push_back(exp_cnt);
    exp_cnt = exp_cnt + 32'd1;
    repeat (10) cyc();
    step_btn = 1'b0;
    repeat (10) cyc();
    checks++;
    if (last_pulse_cyc !== s0 + 9) begin failures++; $display("FAIL step_latency got=%0d exp=%0d", last_pulse_cyc - s0, 9); end
    checks++;
    if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL step_count got=%h exp=1", cycle_cnt); end
    checks++;
    if (state !== 2'b00) begin failures++; $display("FAIL step_state got=%b exp=00", state); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL step_missed got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_halt();
    bit found = 1'b0;
    do_clr();
    rate_sel = 2'd0;
    run_sw = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (state === 2'b01 && pcyc[1:0] == 2'b11) begin
        halt_req = 1'b1;
        found = 1'b1;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL halt_no_tick got=none exp=tick in RUN"); end
    cyc();
    halt_req = 1'b0;
    checks++;
    if (state !== 2'b11) begin failures++; $display("FAIL halt_entry got=%b exp=11", state); end
    step_btn = 1'b1;
    repeat (10) cyc();
    step_btn = 1'b0;
    repeat (10) cyc();
    checks++;
    if (state !== 2'b11) begin failures++; $display("FAIL halt_hold got=%b exp=11", state); end
    checks++;
    if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL halt_count got=%h exp=0", cycle_cnt); end
    run_sw = 1'b0;
    repeat (3) cyc();
    checks++;
    if (state !== 2'b00) begin failures++; $display("FAIL halt_exit got=%b exp=00", state); end
  endtask

  task automatic test_wrap_and_clr();
    bit found = 1'b0;
    int r;
    do_clr();
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    cyc();
    release dut.cycle_cnt;
    checks++;
    if (cycle_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL preload got=%h exp=ffffffff", cycle_cnt); end
    exp_cnt = 32'hFFFF_FFFF;
    exp_q.push_back(exp_cnt);
    exp_cnt = exp_cnt + 32'd1;
    step_btn = 1'b1;
    repeat (10) cyc();
    step_btn = 1'b0;
    repeat (10) cyc();
    checks++;
    if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL wrap_count got=%h exp=0", cycle_cnt); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missed got=%0d pending exp=0", exp_q.size()); end
    step_btn = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (state === 2'b10) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL step_not_reached got=%b exp=10", state); end
    clr = 1'b1;
    @(negedge mclk);
    checks++;
    if (cpu_ce !== 1'b0) begin failures++; $display("FAIL clr_in_step_ce got=%b exp=0", cpu_ce); end
    cyc();
    checks++;
    if (state !== 2'b00) begin failures++; $display("FAIL clr_in_step_state got=%b exp=00", state); end
    checks++;
    if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL clr_in_step_cnt got=%h exp=0", cycle_cnt); end
    clr = 1'b0;
    r = cyc_n;
    exp_cnt = 32'd0;
    last_pulse_cyc = -1;
    exp_q.push_back(exp_cnt);
    exp_cnt = exp_cnt + 32'd1;
    repeat (12) cyc();
    checks++;
    if (last_pulse_cyc !== r + 7) begin failures++; $display("FAIL held_through_clr got=%0d exp=%0d", last_pulse_cyc - r, 7); end
    step_btn = 1'b0;
    repeat (10) cyc();
    checks++;
    if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL held_count got=%h exp=1", cycle_cnt); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL held_missed got=%0d pending exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_run(0, 40);
    test_run(1, 30);
    test_run(3, 70);
    test_step_bounce();
    test_halt();
    test_wrap_and_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; step_btn must be stable this many mclk cycles to be accepted.
REQ-002 SHALL have parameters RATE0_EXP, RATE1_EXP, RATE2_EXP, RATE3_EXP, defaults 18, 20, 24, 26; run tick period is 2^RATEn_EXP mclk cycles.
REQ-003 SHALL have port mclk, input, 1, sole clock, all logic on its rising edge.
REQ-004 SHALL have port clr, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port run_sw, input, 1, asynchronous slide-switch level; 1 requests free-run.
REQ-006 SHALL have port step_btn, input, 1, asynchronous raw push-button; each debounced press issues one CPU cycle.
REQ-007 SHALL have port halt_req, input, 1, synchronous level from the MIPS core (break/syscall-exit decode).
REQ-008 SHALL have port rate_sel, input, 2, selects RATE0..3_EXP.
REQ-009 SHALL have port cpu_ce, output, 1, one-mclk-wide clock-enable pulse to the MIPS core.
REQ-010 SHALL have port state, output, 2, current FSM state for LED display.
REQ-011 SHALL have port cycle_cnt, output, 32, count of issued cpu_ce pulses.

Function
REQ-012 SHALL pass run_sw and step_btn each through a 2-flop synchronizer before any use.
REQ-013 SHALL debounce synchronized step_btn: the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 SHALL produce step_edge for exactly one cycle on each 0->1 transition of the debounced level.
REQ-015 SHALL run a 27-bit free-running prescaler, incremented every cycle and wrapping at all-ones to 0.
REQ-016 SHALL assert tick for one cycle when the low RATEn_EXP prescaler bits (n = rate_sel) are all ones; a rate_sel change takes effect at the next matching count, with no glitch pulse.
REQ-017 SHALL implement FSM states IDLE=00, RUN=01, STEP=10, HALT=11; state output equals current state.
REQ-018 IDLE: cpu_ce=0; synchronized run_sw=1 -> RUN; else step_edge -> STEP; else stay.
REQ-019 RUN: cpu_ce=tick; halt_req=1 -> HALT with cpu_ce=0 that cycle even if tick=1; else run_sw=0 -> IDLE; step_edge ignored.
REQ-020 STEP: cpu_ce=1 for exactly this one cycle; next state HALT if halt_req=1, else IDLE.
REQ-021 HALT: cpu_ce=0; run_sw=0 -> IDLE; step_edge and tick ignored while in HALT.
REQ-022 Latency: cpu_ce asserts the cycle after step_edge (Moore output of STEP).
REQ-023 SHALL increment cycle_cnt by 1 in each cycle cpu_ce=1, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-024 cpu_ce SHALL never be high two consecutive cycles except in RUN when 2^RATEn_EXP = 1.

Reset
REQ-025 On clr=1 at a rising edge, SHALL set state=IDLE, cpu_ce=0, cycle_cnt=0, prescaler=0, synchronizer flops=0, debounced level=0, debounce counter=0.
REQ-026 clr mid-RUN or mid-STEP SHALL suppress any cpu_ce in the reset cycle; operation resumes from IDLE the cycle after clr deasserts.
REQ-027 A button held through reset SHALL require a full debounce period before an edge may be produced.

Structure
REQ-028 SHALL place state encoding constants and default RATEn_EXP values in shared package clk_ctrl_pkg.
REQ-029 SHALL implement synchronizer plus debounce plus edge detect as sub-module btn_debounce, parameterized by DEBOUNCE_CYCLES.

Verification (bench overrides DEBOUNCE_CYCLES=4, RATE0..3_EXP=2,3,4,5)
REQ-030 clr 3 cycles, then idle 20 cycles -> state=00, cpu_ce=0, cycle_cnt=0 throughout.
REQ-031 run_sw=1, rate_sel=0, 40 cycles -> cpu_ce pulses every 4 cycles, cycle_cnt advances by 1 per pulse; run_sw=0 -> state=00, no further pulses.
REQ-032 step_btn bouncing 1,0,1 (1 cycle each), then held 10 cycles -> exactly one cpu_ce, cycle_cnt=1, state returns to 00.
REQ-033 RUN with halt_req=1 on a tick cycle -> no cpu_ce that cycle, state=11; step presses ignored; run_sw=0 -> state=00.
REQ-034 cycle_cnt preloaded to 0xFFFFFFFF via forced state, one step -> cycle_cnt=0x00000000; clr asserted in STEP -> cpu_ce=0, state=00 next cycle.
